// File: rtl/sub_arbiter.sv
// sub_arbiter: one signed subtractor shared by N requesters through a
// round-robin req/gnt front end. Each grant captures a-b, tagged with the
// requester id, into a single registered result slot. The slot drains through
// res_valid/res_ready.
//
// Handshakes:
//   req/gnt          requester i keeps req[i] and its operands stable until
//                    gnt[i] pulses. The operands are consumed in that cycle.
//   res_valid/ready  the slot transfers on a rising clk edge when
//                    res_valid & res_ready. While res_valid=1 the slot holds
//                    res/res_id/res_sat stable.
//
// Optional feature macro: SUB_ARB_SAT_EN. When it is defined, the difference
// is clamped to the W-bit signed range and res_sat flags a clamped result.
module sub_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_bus,
    input  logic [N*W-1:0]   b_bus,
    output logic [N-1:0]     gnt,
    output logic [W:0]       res,
    output logic [IDW-1:0]   res_id,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_sat
);

    logic [IDW-1:0] ptr_q;
    logic [W:0]     res_q, res_d;
    logic [IDW-1:0] res_id_q;
    logic           res_valid_q;
    logic           res_sat_q, sat_d;

    logic           slot_free;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [W-1:0]   a_sel, b_sel;
    logic [W:0]     diff;

    // The slot accepts a new result when it is empty or drains this cycle.
    // While rst is high, no grant is issued.
    assign slot_free = (!res_valid_q || res_ready) && !rst;

    // Round-robin search that starts just after the last winner.
    always_comb begin
        int idx;
        gnt_d     = '0;
        win_id    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (!win_found && req[idx] && slot_free) begin
                win_found  = 1'b1;
                win_id     = IDW'(idx);
                gnt_d[idx] = 1'b1;
            end
        end
    end

    // Select the winner's operands and form the exact W+1-bit difference.
    always_comb begin
        a_sel = a_bus[int'(win_id)*W +: W];
        b_sel = b_bus[int'(win_id)*W +: W];
        diff  = {a_sel[W-1], a_sel} - {b_sel[W-1], b_sel};
    end

`ifdef SUB_ARB_SAT_EN
    // Clamp to the W-bit signed range. Overflow shows when bits W and W-1
    // disagree.
    always_comb begin
        sat_d = diff[W] ^ diff[W-1];
        res_d = diff;
        if (sat_d) begin
            res_d = diff[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
        end
    end
`else
    // Exact difference without clamping.
    always_comb begin
        sat_d = 1'b0;
        res_d = diff;
    end
`endif

    // Result slot and round-robin pointer. A new grant overrides a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= IDW'(N - 1);
            res_q       <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
        end else if (win_found) begin
            ptr_q       <= win_id;
            res_q       <= res_d;
            res_id_q    <= win_id;
            res_valid_q <= 1'b1;
            res_sat_q   <= sat_d;
        end else if (res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign gnt       = gnt_d;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign res_sat   = res_sat_q;

endmodule
